// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, load/store funct3 encodings, LSU FSM states.
package riscv_pkg;

  localparam int unsigned LSU_WIDTH      = 32;
  localparam int unsigned LSU_BYTE_LANES = LSU_WIDTH / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and lane replication on the
// request side, load extraction and sign/zero extension on the response side.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]                  st_off_i,
  input  logic [2:0]                  st_funct3_i,
  input  logic [LSU_WIDTH-1:0]        st_wdata_i,
  input  logic [1:0]                  ld_off_i,
  input  logic [2:0]                  ld_funct3_i,
  input  logic [LSU_WIDTH-1:0]        ld_raw_i,
  output logic [LSU_BYTE_LANES-1:0]   be_o,
  output logic [LSU_WIDTH-1:0]        st_data_o,
  output logic [LSU_WIDTH-1:0]        ld_data_o,
  output logic                        aligned_o
);

  logic [LSU_WIDTH-1:0] ld_sh;

  // Legal size with natural alignment; unused funct3 encodings are rejected here too.
  always_comb begin
    aligned_o = 1'b0;
    case (st_funct3_i)
      F3_B, F3_BU: aligned_o = 1'b1;
      F3_H, F3_HU: aligned_o = ~st_off_i[0];
      F3_W:        aligned_o = (st_off_i == 2'b00);
      default:     aligned_o = 1'b0;
    endcase
  end

  // Store side: byte enables and data replicated across every lane.
  always_comb begin
    case (st_funct3_i[1:0])
      2'b00: begin
        be_o      = 4'b0001 << st_off_i;
        st_data_o = {4{st_wdata_i[7:0]}};
      end
      2'b01: begin
        be_o      = 4'b0011 << st_off_i;
        st_data_o = {2{st_wdata_i[15:0]}};
      end
      default: begin
        be_o      = '1;
        st_data_o = st_wdata_i;
      end
    endcase
  end

  // Load side: shift the addressed lane down, then extend; funct3[2] selects unsigned.
  always_comb begin
    ld_sh = ld_raw_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i[1:0])
      2'b00:   ld_data_o = {{24{ld_sh[7]  & ~ld_funct3_i[2]}}, ld_sh[7:0]};
      2'b01:   ld_data_o = {{16{ld_sh[15] & ~ld_funct3_i[2]}}, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns the ALU effective address into a single data-memory
// transaction on a req/gnt/rvalid bus and stalls the core until it completes.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH      = LSU_WIDTH,
  parameter int unsigned BYTE_LANES = LSU_BYTE_LANES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lsu_read,
  input  logic                  lsu_write,
  input  logic [2:0]            funct3,
  input  logic [WIDTH-1:0]      addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic                  done,
  output logic                  stall,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_addr,
  output logic [BYTE_LANES-1:0] mem_be,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [WIDTH-1:0]      mem_rdata
);

  lsu_state_e state_q, state_d;

  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  mem_we_q;
  logic [WIDTH-1:0]      mem_addr_q;
  logic [BYTE_LANES-1:0] mem_be_q;
  logic [WIDTH-1:0]      mem_wdata_q;
  logic [WIDTH-1:0]      rdata_q;

  logic                  start;
  logic                  accept;
  logic                  capture;
  logic                  stall_c;
  logic                  misaligned_c;
  logic                  aligned;
  logic [BYTE_LANES-1:0] be;
  logic [WIDTH-1:0]      st_data;
  logic [WIDTH-1:0]      ld_data;

  assign start = lsu_read | lsu_write;

  // Request side works on the live execute inputs; response side on the latched access.
  lsu_align u_align (
    .st_off_i    (addr[1:0]),
    .st_funct3_i (funct3),
    .st_wdata_i  (wdata),
    .ld_off_i    (off_q),
    .ld_funct3_i (f3_q),
    .ld_raw_i    (mem_rdata),
    .be_o        (be),
    .st_data_o   (st_data),
    .ld_data_o   (ld_data),
    .aligned_o   (aligned)
  );

  // Next-state and handshake decode; a new access may start from IDLE or RESP.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture      = 1'b0;
    stall_c      = 1'b0;
    misaligned_c = 1'b0;
    case (state_q)
      LSU_IDLE, LSU_RESP: begin
        state_d = LSU_IDLE;
        if (start) begin
          if (aligned) begin
            accept  = 1'b1;
            stall_c = 1'b1;
            state_d = LSU_REQ;
          end else begin
            misaligned_c = 1'b1;
          end
        end
      end
      LSU_REQ: begin
        stall_c = 1'b1;
        if (mem_gnt) state_d = mem_we_q ? LSU_RESP : LSU_WAIT;
      end
      LSU_WAIT: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = LSU_RESP;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // FSM state register; reset abandons any outstanding bus access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= LSU_IDLE;
    else          state_q <= state_d;
  end

  // Capture the accepted access; bus fields stay stable until the next accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off_q       <= '0;
      f3_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else if (accept) begin
      off_q       <= addr[1:0];
      f3_q        <= funct3;
      mem_we_q    <= lsu_write & ~lsu_read;
      mem_addr_q  <= {addr[WIDTH-1:2], 2'b00};
      mem_be_q    <= be;
      mem_wdata_q <= st_data;
    end
  end

  // Load result register; holds until the next load completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     rdata_q <= '0;
    else if (capture) rdata_q <= ld_data;
  end

  assign rdata      = rdata_q;
  assign done       = (state_q == LSU_RESP);
  assign stall      = stall_c;
  assign misaligned = misaligned_c;
  assign mem_req    = (state_q == LSU_REQ);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a scripted bus responder, immediate-assertion
// checks and a queue of expected load results popped on each done pulse.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lsu_read = 1'b0;
  logic        lsu_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .BYTE_LANES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .lsu_read   (lsu_read),
    .lsu_write  (lsu_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .done       (done),
    .stall      (stall),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rdata"},      rdata, 0);
    chk({tag, " done"},       done, 0);
    chk({tag, " stall"},      stall, 0);
    chk({tag, " misaligned"}, misaligned, 0);
    chk({tag, " mem_req"},    mem_req, 0);
    chk({tag, " mem_we"},     mem_we, 0);
    chk({tag, " mem_addr"},   mem_addr, 0);
    chk({tag, " mem_be"},     mem_be, 0);
    chk({tag, " mem_wdata"},  mem_wdata, 0);
  endtask

  // One legal access; gnt arrives on REQ cycle gnt_dly, rvalid on WAIT cycle rv_dly.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int unsigned gnt_dly, input int unsigned rv_dly,
                        input logic [31:0] word, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    logic [31:0] exp_addr;
    exp_addr = {a[31:2], 2'b00};
    if (rd) sb_q.push_back(exp_rd);
    lsu_read = rd; lsu_write = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk({tag, " start stall"}, stall, 1);
    chk({tag, " start misaligned"}, misaligned, 0);
    chk({tag, " start mem_req"}, mem_req, 0);
    cyc();
    lsu_read = 0; lsu_write = 0; addr = $urandom; wdata = $urandom;
    for (int unsigned i = 0; i <= gnt_dly; i++) begin
      mem_gnt = (i == gnt_dly);
      #1;
      chk({tag, " req mem_req"}, mem_req, 1);
      chk({tag, " req stall"}, stall, 1);
      chk({tag, " req mem_we"}, mem_we, wr & ~rd);
      chk({tag, " req mem_addr"}, mem_addr, exp_addr);
      chk({tag, " req mem_be"}, mem_be, exp_be);
      if (wr && !rd) chk({tag, " req mem_wdata"}, mem_wdata, exp_wd);
      cyc();
    end
    mem_gnt = 0;
    if (rd) begin
      for (int unsigned j = 0; j <= rv_dly; j++) begin
        mem_rvalid = (j == rv_dly);
        mem_rdata  = (j == rv_dly) ? word : $urandom;
        #1;
        chk({tag, " wait mem_req"}, mem_req, 0);
        chk({tag, " wait stall"}, stall, 1);
        chk({tag, " wait done"}, done, 0);
        cyc();
      end
      mem_rvalid = 0;
      mem_rdata  = $urandom;
    end
    #1;
    chk({tag, " resp done"}, done, 1);
    chk({tag, " resp stall"}, stall, 0);
    chk({tag, " resp mem_req"}, mem_req, 0);
    if (rd) begin
      if (sb_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s scoreboard: observed empty queue expected entry", tag);
      end else begin
        chk({tag, " rdata"}, rdata, sb_q.pop_front());
      end
    end
    cyc();
    #1;
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle stall"}, stall, 0);
  endtask

  // Misaligned or illegal-size access: one-cycle flag, no stall, no bus traffic.
  task automatic bad(input string tag, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a);
    lsu_read = rd; lsu_write = wr; funct3 = f3; addr = a;
    #1;
    chk({tag, " misaligned"}, misaligned, 1);
    chk({tag, " stall"}, stall, 0);
    chk({tag, " mem_req"}, mem_req, 0);
    cyc();
    lsu_read = 0; lsu_write = 0;
    #1;
    chk({tag, " misaligned after"}, misaligned, 0);
    chk({tag, " mem_req after"}, mem_req, 0);
    chk({tag, " done after"}, done, 0);
    cyc();
    #1;
    chk({tag, " mem_req later"}, mem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc();
    #1;
    chk_zero("reset");
    reset_n = 1;
    cyc();
    #1;
    chk("post-reset done", done, 0);

    // Stores
    access("SW", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 0);
    chk("rdata untouched by store", rdata, 0);
    access("SB", 0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 0);
    access("SH", 0, 1, 3'b001, 32'h102, 32'h1234BEEF, 1, 0, 0, 4'b1100, 32'hBEEFBEEF, 0);

    // Loads with extension
    access("LB",  1, 0, 3'b000, 32'h102, 0, 0, 0, 32'h12805634, 4'b0100, 0, 32'hFFFFFF80);
    access("LBU", 1, 0, 3'b100, 32'h102, 0, 0, 0, 32'h12805634, 4'b0100, 0, 32'h00000080);
    access("LHU", 1, 0, 3'b101, 32'h102, 0, 0, 0, 32'h12805634, 4'b1100, 0, 32'h00001280);
    access("LH",  1, 0, 3'b001, 32'h100, 0, 0, 0, 32'h00008001, 4'b0011, 0, 32'hFFFF8001);
    access("LB0", 1, 0, 3'b000, 32'h101, 0, 0, 2, 32'h00007F00, 4'b0010, 0, 32'h0000007F);
    access("LW",  1, 0, 3'b010, 32'h104, 0, 1, 0, 32'hCAFEF00D, 4'b1111, 0, 32'hCAFEF00D);
    access("SW2", 0, 1, 3'b010, 32'h108, 32'h01020304, 0, 0, 0, 4'b1111, 32'h01020304, 0);
    chk("rdata held over store", rdata, 32'hCAFEF00D);

    // Read and write together: the load wins
    access("RDWR", 1, 1, 3'b010, 32'h10C, 32'hFFFFFFFF, 0, 0, 32'h11223344, 4'b1111, 0, 32'h11223344);

    // Misaligned / illegal
    bad("LW mis",  1, 0, 3'b010, 32'h102);
    bad("F3 011",  1, 0, 3'b011, 32'h100);
    bad("SH mis",  0, 1, 3'b001, 32'h101);
    bad("F3 110",  0, 1, 3'b110, 32'h100);

    // Slow bus: gnt on third REQ cycle, rvalid two cycles after gnt
    access("LW slow", 1, 0, 3'b010, 32'h200, 0, 2, 1, 32'h89ABCDEF, 4'b1111, 0, 32'h89ABCDEF);

    // Reset while waiting for read data
    lsu_read = 1; funct3 = 3'b010; addr = 32'h300;
    #1;
    chk("rst start stall", stall, 1);
    cyc();
    lsu_read = 0;
    mem_gnt = 1;
    #1;
    chk("rst req mem_req", mem_req, 1);
    cyc();
    mem_gnt = 0;
    #1;
    chk("rst wait stall", stall, 1);
    reset_n = 0;
    #1;
    chk_zero("mid-reset");
    cyc();
    reset_n = 1;
    mem_rvalid = 1;
    mem_rdata = 32'hDEADDEAD;
    cyc();
    mem_rvalid = 0;
    #1;
    chk("stale rvalid done", done, 0);
    chk("stale rvalid stall", stall, 0);
    chk("stale rvalid rdata", rdata, 0);
    access("LW after rst", 1, 0, 3'b010, 32'h300, 0, 0, 0, 32'h5A5A0001, 4'b1111, 0, 32'h5A5A0001);

    chk("scoreboard drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
